// File: rtl/sadd_seq.sv
// rtl/sadd_seq.sv - bit-serial add/subtract sequencer with start/done handshake
module sadd_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           s_bit;
  logic           c_next;

  // One-bit full adder on the current LSBs; subtraction is a + ~b + 1.
  always_comb begin
    s_bit  = op_a[0] ^ op_b[0] ^ carry;
    c_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= c_next;
          sum   <= {s_bit, sum[W-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            cout  <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sadd_seq.sv
// tb/tb_sadd_seq.sv - directed table-driven bench for sadd_seq
module tb_sadd_seq;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  sadd_seq #(.W(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Step one edge, ending on the following negedge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Load at E0, then count edges until done; lat = k when done is seen after Ek.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                        output int lat, output logic [7:0] rs, output logic rc);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    check("busy_after_load", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    rs = sum;
    rc = cout;
  endtask

  initial begin
    int lat;
    logic [7:0] rs;
    logic rc;
    int done_cnt;
    int done_edge [$];
    logic [7:0] done_sum [$];

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
    vecs[4] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0};

    rst_b = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk);
    step(); step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    rst_b = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, rs, rc);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("v%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
      check($sformatf("v%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
      step();
      check($sformatf("v%0d_done_drop", i), 32'(done), 32'd0);
      check($sformatf("v%0d_busy_drop", i), 32'(busy), 32'd0);
      step();
      check($sformatf("v%0d_sum_hold", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("v%0d_cout_hold", i), 32'(cout), 32'(vecs[i].exp_cout));
    end

    // Starts at E3 (RUN) and E9 (DONE) with new operands must be ignored.
    done_cnt = 0;
    done_edge.delete();
    done_sum.delete();
    for (int e = 0; e < 16; e++) begin
      start = (e == 0 || e == 3 || e == 9);
      a = (e == 0) ? 8'h11 : 8'h77;
      b = (e == 0) ? 8'h22 : 8'h55;
      sub = 1'b0;
      step();
      if (done) begin
        done_cnt++;
        done_edge.push_back(e);
        done_sum.push_back(sum);
      end
    end
    start = 1'b0;
    check("ign_done_count", 32'(done_cnt), 32'd1);
    if (done_cnt >= 1) begin
      check("ign_done_edge", 32'(done_edge[0]), 32'd8);
      check("ign_sum", 32'(done_sum[0]), 32'h33);
    end
    check("ign_idle_busy", 32'(busy), 32'd0);

    // Reset asserted at E4 of a running add.
    a = 8'h5A; b = 8'h33; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_b = 1'b0;
    step();
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_sum",  32'(sum),  32'd0);
    check("rst_mid_cout", 32'(cout), 32'd0);
    done_cnt = 0;
    for (int e = 0; e < 10; e++) begin
      if (e == 2) rst_b = 1'b1;
      step();
      if (done) done_cnt++;
    end
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    run_op(8'h01, 8'h02, 1'b0, lat, rs, rc);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_sum", 32'(rs), 32'h03);
    step(); step();

    // start held high: loads every W+2 edges.
    done_edge.delete();
    done_sum.delete();
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    for (int e = 0; e < 30; e++) begin
      step();
      if (done) begin
        done_edge.push_back(e);
        done_sum.push_back(sum);
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(done_edge.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < done_edge.size()) begin
        check($sformatf("held_done_edge%0d", k), 32'(done_edge[k]), 32'(8 + 10 * k));
        check($sformatf("held_sum%0d", k), 32'(done_sum[k]), 32'h10);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
